// File: rtl/cache_pkg.sv
// Shared types and line-geometry constants for the cache/memory arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int LINE_BYTES     = DEF_LINE_WORDS * 8;
  localparam int OFFSET_W       = $clog2(LINE_BYTES);
  localparam int BEAT_W         = $clog2(DEF_LINE_WORDS);

  // Geometry helpers so a top built with a non-default line size stays consistent
  function automatic int offset_w_of(input int line_words);
    return $clog2(line_words * 8);
  endfunction

  function automatic int beat_w_of(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the I-cache, bit 1 the D-cache.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the most recent winner; reset to the I-cache so a first tie goes to the D-cache
  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one beat-oriented memory port between I-cache refills and D-cache refills/writebacks.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_data,
  output logic              ic_beat,
  output logic              ic_refilled,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wnext,
  output logic [DATA_W-1:0] dc_data,
  output logic              dc_beat,
  output logic              dc_refilled,
  output logic              dc_write_finish,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int OFF_W = offset_w_of(LINE_WORDS);
  localparam int CNT_W = beat_w_of(LINE_WORDS);
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  state_t            state, state_next;
  owner_t            owner;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  beat;
  logic [1:0]        grant;
  logic              grant_fire;
  logic              last_beat;

  assign grant_fire = (state == IDLE) && (ic_req || dc_req);
  assign last_beat  = (beat == CNT_W'(LINE_WORDS - 1));

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({dc_req, ic_req}),
    .advance (grant_fire),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the purely state-decoded memory handshake and completion pulses
  always_comb begin
    state_next      = state;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    dc_wnext        = 1'b0;
    ic_refilled     = 1'b0;
    dc_refilled     = 1'b0;
    dc_write_finish = 1'b0;
    case (state)
      IDLE: begin
        if (ic_req || dc_req) state_next = BURST;
      end
      BURST: begin
        mem_req  = 1'b1;
        mem_we   = we;
        mem_addr = base + {{(ADDR_W-CNT_W-3){1'b0}}, beat, 3'b000};
        if (we) mem_wdata = dc_wdata;
        dc_wnext = we && mem_ack;
        if (mem_ack && last_beat) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
        if (owner == OWNER_IC) begin
          ic_refilled = 1'b1;
        end else if (we) begin
          dc_write_finish = 1'b1;
        end else begin
          dc_refilled = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transfer context and registered read-beat delivery; the beat counter wraps on the last ack
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWNER_IC;
      we      <= 1'b0;
      base    <= '0;
      beat    <= '0;
      ic_data <= '0;
      dc_data <= '0;
      ic_beat <= 1'b0;
      dc_beat <= 1'b0;
    end else begin
      ic_beat <= 1'b0;
      dc_beat <= 1'b0;
      if (grant_fire) begin
        owner <= grant[1] ? OWNER_DC : OWNER_IC;
        we    <= grant[1] & dc_we;
        base  <= (grant[1] ? dc_addr : ic_addr) & BASE_MASK;
        beat  <= '0;
      end
      if ((state == BURST) && mem_ack) begin
        beat <= beat + 1'b1;
        if (!we) begin
          if (owner == OWNER_DC) begin
            dc_data <= mem_rdata;
            dc_beat <= 1'b1;
          end else begin
            ic_data <= mem_rdata;
            ic_beat <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a vector table of single-owner lines plus
// hand-written tie, stall and mid-burst reset sequences against a bench-side memory.
module tb_cache_mem_arbiter;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, dc_we, mem_ack;
  logic [63:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic [63:0] ic_data, dc_data, mem_addr, mem_wdata;
  logic        ic_beat, ic_refilled, dc_wnext, dc_beat, dc_refilled, dc_write_finish;
  logic        mem_req, mem_we;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit          useDc;
    bit          dcWe;
    logic [63:0] addr;
    int          stall;
    bit          expWe;
    logic [63:0] expBase;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_data(ic_data), .ic_beat(ic_beat),
    .ic_refilled(ic_refilled),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_data(dc_data), .dc_beat(dc_beat),
    .dc_refilled(dc_refilled), .dc_write_finish(dc_write_finish),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] rpat(input logic [63:0] a);
    return a ^ 64'h5A5A_A5A5_0000_0000;
  endfunction

  function automatic logic [63:0] wpat(input logic [63:0] b, input int i);
    return {32'hC3C3_C3C3, b[15:0], 16'(i)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ic_data"}, ic_data, 64'h0);
    checkOutput({tag, " dc_data"}, dc_data, 64'h0);
    checkOutput({tag, " mem_addr"}, mem_addr, 64'h0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 64'h0);
    checkOutput({tag, " flags"},
                {ic_beat, ic_refilled, dc_wnext, dc_beat, dc_refilled, dc_write_finish, mem_req, mem_we},
                64'h0);
  endtask

  task automatic applyStimulus(input vec_t v);
    ic_req = !v.useDc;
    dc_req = v.useDc;
    dc_we  = v.dcWe;
    if (v.useDc) dc_addr = v.addr;
    else         ic_addr = v.addr;
  endtask

  // Plays memory for one line from the grant edge to the done pulse, checking every cycle
  task automatic runLine(input bit expDc, input bit expWe, input logic [63:0] expBase, input int stall);
    int issued  = 0;
    int seen    = 0;
    int waitCnt = 0;
    int cyc     = 0;
    bit done    = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      if (cyc == 1) begin
        if (expDc) begin
          dc_addr = 64'hFFFF_0000_1234_5670;
          dc_we   = ~dc_we;
        end else begin
          ic_addr = 64'hFFFF_0000_1234_5670;
        end
      end
      if (expWe) dc_wdata = wpat(expBase, issued);
      #1;
      if (expDc) begin
        checkOutput("ic_beat non-owner", ic_beat, 1'b0);
        if (dc_beat) begin
          checkOutput("dc_data", dc_data, rpat(expBase + 64'(seen * 8)));
          seen++;
        end
      end else begin
        checkOutput("dc_beat non-owner", dc_beat, 1'b0);
        if (ic_beat) begin
          checkOutput("ic_data", ic_data, rpat(expBase + 64'(seen * 8)));
          seen++;
        end
      end
      if (mem_req) begin
        checkOutput("mem_addr", mem_addr, expBase + 64'(issued * 8));
        checkOutput("mem_we", mem_we, expWe);
        if (expWe) checkOutput("mem_wdata", mem_wdata, wpat(expBase, issued));
        checkOutput("pulse during burst", {ic_refilled, dc_refilled, dc_write_finish}, 3'b000);
        if (waitCnt == stall) begin
          mem_ack   = 1'b1;
          mem_rdata = rpat(expBase + 64'(issued * 8));
          #1;
          checkOutput("dc_wnext on ack", dc_wnext, expWe);
          issued++;
          waitCnt = 0;
        end else begin
          #1;
          checkOutput("dc_wnext stalled", dc_wnext, 1'b0);
          waitCnt++;
        end
      end else begin
        done = 1;
        checkOutput("beats issued", 64'(issued), 64'(LW));
        checkOutput("beats delivered", 64'(seen), expWe ? 64'd0 : 64'(LW));
        checkOutput("ic_refilled", ic_refilled, !expDc);
        checkOutput("dc_refilled", dc_refilled, expDc && !expWe);
        checkOutput("dc_write_finish", dc_write_finish, expDc && expWe);
        checkOutput("line cycles", 64'(cyc), 64'(LW * (stall + 1) + 1));
        if (expDc) dc_req = 1'b0;
        else       ic_req = 1'b0;
      end
    end
    if (!done) checkOutput("line timeout", 64'd0, 64'd1);
  endtask

  task automatic idleCheck();
    @(negedge clk);
    #1;
    checkOutput("idle mem_req", mem_req, 1'b0);
    checkOutput("idle pulses/beats",
                {ic_beat, dc_beat, ic_refilled, dc_refilled, dc_write_finish}, 5'b0);
  endtask

  initial begin
    vecs[0] = '{useDc: 0, dcWe: 0, addr: 64'h1038, stall: 0, expWe: 0, expBase: 64'h1020};
    vecs[1] = '{useDc: 1, dcWe: 1, addr: 64'h2000, stall: 0, expWe: 1, expBase: 64'h2000};
    vecs[2] = '{useDc: 1, dcWe: 0, addr: 64'h4018, stall: 3, expWe: 0, expBase: 64'h4000};
    vecs[3] = '{useDc: 0, dcWe: 0, addr: 64'hFFFF_FFFF_FFFF_FFE7, stall: 1, expWe: 0,
                expBase: 64'hFFFF_FFFF_FFFF_FFE0};
    vecs[4] = '{useDc: 1, dcWe: 1, addr: 64'h5008, stall: 3, expWe: 1, expBase: 64'h5000};
    vecs[5] = '{useDc: 0, dcWe: 1, addr: 64'h7030, stall: 0, expWe: 0, expBase: 64'h7020};

    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkAllZero("reset");

    // Tie straight out of reset goes to the D-cache; re-raising D in the IDLE slot then loses to I
    ic_req = 1'b1; ic_addr = 64'h8018;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h6008;
    runLine(1'b1, 1'b0, 64'h6000, 0);
    @(negedge clk);
    #1;
    checkOutput("tie gap mem_req", mem_req, 1'b0);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 64'h6100;
    runLine(1'b0, 1'b0, 64'h8000, 0);
    @(negedge clk);
    #1;
    checkOutput("tie gap2 mem_req", mem_req, 1'b0);
    runLine(1'b1, 1'b1, 64'h6100, 0);
    idleCheck();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      runLine(vecs[i].useDc, vecs[i].expWe, vecs[i].expBase, vecs[i].stall);
      idleCheck();
    end

    // Reset lands together with the ack of beat 2 of a D refill
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 64'h3010;
    @(negedge clk);
    #1;
    checkOutput("rst seq beat0 addr", mem_addr, 64'h3000);
    mem_ack = 1'b1; mem_rdata = rpat(64'h3000);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("rst seq beat1 addr", mem_addr, 64'h3008);
    checkOutput("rst seq dc_beat0", dc_beat, 1'b1);
    mem_ack = 1'b1; mem_rdata = rpat(64'h3008);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("rst seq beat2 addr", mem_addr, 64'h3010);
    mem_ack = 1'b1; mem_rdata = rpat(64'h3010); rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; rst = 1'b0; dc_req = 1'b0;
    #1;
    checkAllZero("after mid-burst reset");
    @(negedge clk);
    #1;
    checkOutput("no dc_refilled after reset", dc_refilled, 1'b0);
    checkOutput("idle after reset mem_req", mem_req, 1'b0);
    ic_req = 1'b1; ic_addr = 64'h9008;
    runLine(1'b0, 1'b0, 64'h9000, 0);
    idleCheck();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
